i2c_slave_wb_bridge: RTL and testbench

//  I2C slave endpoint that bridges bus transactions onto a Wishbone master port.
//  An external I2C master writes a register pointer, then writes or reads 8-bit registers.

---
 rtl/i2c_slave_wb_bridge.sv | 275 +++++++++++++++++++++++++++
 tb/tb_i2c_slave_wb_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_wb_bridge.sv
// I2C slave endpoint that turns register-pointer accesses from an external
// I2C master into single Wishbone cycles on a downstream register bank.
// SCL is stretched while a Wishbone cycle is outstanding.
`timescale 1ns/1ps
module i2c_slave_wb_bridge #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h22,
    parameter int WB_TIMEOUT     = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     scl_o,
    output logic                     sda_o
);

    localparam int          TW   = $clog2(WB_TIMEOUT + 1);
    localparam logic [3:0]  BITS = 4'(I2C_DATA_WIDTH);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ADDR_ACK = 4'd2,
        S_PTR      = 4'd3,
        S_PTR_ACK  = 4'd4,
        S_WR_DATA  = 4'd5,
        S_WB_WR    = 4'd6,
        S_WR_ACK   = 4'd7,
        S_WB_RD    = 4'd8,
        S_RD_DATA  = 4'd9,
        S_RD_ACK   = 4'd10,
        S_IGNORE   = 4'd11
    } state_t;

    logic [1:0]                r_scl_sync;
    logic [1:0]                r_sda_sync;
    logic                      r_scl_prev;
    logic                      r_sda_prev;

    state_t                    r_state;
    logic [3:0]                r_bitcnt;
    logic [I2C_DATA_WIDTH-1:0] r_shift;
    logic                      r_rw;
    logic                      r_mack;
    logic [WB_ADDR_WIDTH-1:0]  r_ptr;
    logic [TW-1:0]             r_timer;
    logic                      r_cyc;
    logic                      r_we;
    logic [WB_ADDR_WIDTH-1:0]  r_adr;
    logic [WB_DATA_WIDTH-1:0]  r_dat;
    logic                      r_scl_o;
    logic                      r_sda_o;

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_in_wb;
    logic w_timeout;

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    // Conditions need SCL high on both sides of the SDA change.
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
    // SCL is held low in these states, so a bus condition cannot be genuine.
    assign w_in_wb    = (r_state == S_WB_WR) || (r_state == S_WB_RD);
    assign w_timeout  = (r_timer == TW'(WB_TIMEOUT - 1));

    assign cyc_o = r_cyc;
    assign stb_o = r_cyc;
    assign we_o  = r_we;
    assign adr_o = r_adr;
    assign dat_o = r_dat;
    assign scl_o = r_scl_o;
    assign sda_o = r_sda_o;

    // Two-flop synchronizers for the pins plus previous-value registers for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
        end
    end

    // Protocol FSM with registered I2C drive and Wishbone master outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 4'd0;
            r_shift  <= '0;
            r_rw     <= 1'b0;
            r_mack   <= 1'b0;
            r_ptr    <= '0;
            r_timer  <= '0;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_scl_o  <= 1'b1;
            r_sda_o  <= 1'b1;
        end else if ((w_start || w_stop) && !w_in_wb) begin
            r_sda_o  <= 1'b1;
            r_scl_o  <= 1'b1;
            r_bitcnt <= 4'd0;
            r_state  <= w_start ? S_ADDR : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_ADDR: begin
                    if (w_scl_rise) begin
                        r_shift  <= {r_shift[I2C_DATA_WIDTH-2:0], w_sda};
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end else if (w_scl_fall && (r_bitcnt == BITS)) begin
                        if (r_shift[I2C_DATA_WIDTH-1:I2C_DATA_WIDTH-I2C_ADDR_WIDTH] == SLAVE_ADDR) begin
                            r_rw    <= r_shift[0];
                            r_sda_o <= 1'b0;
                            r_state <= S_ADDR_ACK;
                        end else begin
                            r_state <= S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        r_sda_o  <= 1'b1;
                        r_bitcnt <= 4'd0;
                        if (r_rw) begin
                            r_scl_o <= 1'b0;
                            r_cyc   <= 1'b1;
                            r_we    <= 1'b0;
                            r_adr   <= r_ptr;
                            r_timer <= '0;
                            r_state <= S_WB_RD;
                        end else begin
                            r_state <= S_PTR;
                        end
                    end
                end
                S_PTR: begin
                    if (w_scl_rise) begin
                        r_shift  <= {r_shift[I2C_DATA_WIDTH-2:0], w_sda};
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end else if (w_scl_fall && (r_bitcnt == BITS)) begin
                        r_ptr   <= r_shift[WB_ADDR_WIDTH-1:0];
                        r_sda_o <= 1'b0;
                        r_state <= S_PTR_ACK;
                    end
                end
                S_PTR_ACK, S_WR_ACK: begin
                    if (w_scl_fall) begin
                        r_sda_o  <= 1'b1;
                        r_bitcnt <= 4'd0;
                        r_state  <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (w_scl_rise) begin
                        r_shift  <= {r_shift[I2C_DATA_WIDTH-2:0], w_sda};
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end else if (w_scl_fall && (r_bitcnt == BITS)) begin
                        r_scl_o <= 1'b0;
                        r_cyc   <= 1'b1;
                        r_we    <= 1'b1;
                        r_adr   <= r_ptr;
                        r_dat   <= r_shift;
                        r_timer <= '0;
                        r_state <= S_WB_WR;
                    end
                end
                S_WB_WR: begin
                    if (ack_i) begin
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        r_scl_o <= 1'b1;
                        r_sda_o <= 1'b0;
                        r_ptr   <= r_ptr + WB_ADDR_WIDTH'(1);
                        r_state <= S_WR_ACK;
                    end else if (w_timeout) begin
                        // Abandoned write: NACK the byte, pointer stays put.
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        r_scl_o <= 1'b1;
                        r_sda_o <= 1'b1;
                        r_state <= S_WR_ACK;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_WB_RD: begin
                    // SCL is still held low here, so the MSB goes out with the release.
                    if (ack_i) begin
                        r_cyc    <= 1'b0;
                        r_scl_o  <= 1'b1;
                        r_shift  <= dat_i;
                        r_sda_o  <= dat_i[WB_DATA_WIDTH-1];
                        r_ptr    <= r_ptr + WB_ADDR_WIDTH'(1);
                        r_bitcnt <= 4'd0;
                        r_state  <= S_RD_DATA;
                    end else if (w_timeout) begin
                        r_cyc    <= 1'b0;
                        r_scl_o  <= 1'b1;
                        r_shift  <= {I2C_DATA_WIDTH{1'b1}};
                        r_sda_o  <= 1'b1;
                        r_bitcnt <= 4'd0;
                        r_state  <= S_RD_DATA;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_RD_DATA: begin
                    if (w_scl_rise) begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bitcnt == BITS) begin
                            r_sda_o <= 1'b1;
                            r_mack  <= 1'b0;
                            r_state <= S_RD_ACK;
                        end else begin
                            r_sda_o <= r_shift[I2C_DATA_WIDTH-2];
                            r_shift <= {r_shift[I2C_DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda) begin
                            r_state <= S_IGNORE;
                        end else begin
                            r_mack <= 1'b1;
                        end
                    end else if (w_scl_fall && r_mack) begin
                        r_scl_o <= 1'b0;
                        r_cyc   <= 1'b1;
                        r_we    <= 1'b0;
                        r_adr   <= r_ptr;
                        r_timer <= '0;
                        r_state <= S_WB_RD;
                    end
                end
                S_IGNORE: begin
                    r_sda_o <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_wb_bridge.sv
// Directed bench: bit-banged I2C master, a small Wishbone register bank,
// and a transaction-level model of the expected Wishbone cycles and data.
`timescale 1ns/1ps
module tb_i2c_slave_wb_bridge;

    localparam int Q = 100;          // quarter SCL period in ns
    localparam int WAIT_MAX = 3000;  // bound on any wait, in 10 ns steps/cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cyc_o, stb_o, we_o, scl_o, sda_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack_i;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    wire        scl_line = scl_m & scl_o;
    wire        sda_line = sda_m & sda_o;

    int errors = 0;
    int checks = 0;

    // Downstream register bank
    logic [7:0] mem [4];
    logic [1:0] lat;
    logic       ack_en = 1'b1;
    logic       pre_wr = 1'b0;
    logic [1:0] pre_adr = 2'd0;
    logic [7:0] pre_dat = 8'd0;

    // Model state
    typedef struct { logic we; logic [1:0] adr; logic [7:0] dat; } wb_exp_t;
    wb_exp_t    exp_q[$];
    logic [7:0] model_mem [4];
    logic [1:0] model_ptr = 2'd0;
    int         cyc_run = 0;
    int         last_run = 0;
    logic       prev_stb = 1'b0;
    logic [10:0] prev_bus = '0;

    i2c_slave_wb_bridge dut (
        .clk_i(clk), .rst_i(rst),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i),
        .scl_i(scl_line), .sda_i(sda_line), .scl_o(scl_o), .sda_o(sda_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    assign dat_i = mem[adr_o];

    // Register bank: acks after a short latency unless ack_en is low
    always @(posedge clk) begin
        if (pre_wr) mem[pre_adr] <= pre_dat;
        if (rst) begin
            ack_i <= 1'b0;
            lat   <= 2'd0;
        end else begin
            ack_i <= 1'b0;
            if (cyc_o && stb_o && !ack_i) begin
                if (ack_en && lat == 2'd2) begin
                    ack_i <= 1'b1;
                    lat   <= 2'd0;
                    if (we_o) mem[adr_o] <= dat_o;
                end else begin
                    lat <= lat + 2'd1;
                end
            end else begin
                lat <= 2'd0;
            end
        end
    end

    // Per-cycle compare against the expected Wishbone traffic
    always @(negedge clk) begin
        if (rst) begin
            prev_stb = 1'b0;
            cyc_run  = 0;
        end else begin
            chk("cyc_eq_stb", {31'd0, cyc_o}, {31'd0, stb_o});
            if (stb_o) begin
                chk("scl_stretch", {31'd0, scl_o}, 32'd0);
                if (prev_stb) begin
                    chk("bus_stable", {21'd0, we_o, adr_o, dat_o}, {21'd0, prev_bus});
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got cycle we=%0d adr=%0h expected none", we_o, adr_o);
                end else begin
                    wb_exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_we", {31'd0, we_o}, {31'd0, e.we});
                    chk("wb_adr", {30'd0, adr_o}, {30'd0, e.adr});
                    if (e.we) chk("wb_dat", {24'd0, dat_o}, {24'd0, e.dat});
                end
                cyc_run++;
            end else if (prev_stb) begin
                last_run = cyc_run;
                cyc_run  = 0;
            end
            prev_stb = stb_o;
            prev_bus = {we_o, adr_o, dat_o};
        end
    end

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        pre_adr = a; pre_dat = d; pre_wr = 1'b1;
        model_mem[a] = d;
        @(posedge clk); #1;
        pre_wr = 1'b0;
    endtask

    task automatic model_wr(input logic [7:0] d);
        exp_q.push_back('{we: 1'b1, adr: model_ptr, dat: d});
        model_mem[model_ptr] = d;
        model_ptr = model_ptr + 2'd1;
    endtask

    task automatic model_rd(output logic [7:0] d);
        exp_q.push_back('{we: 1'b0, adr: model_ptr, dat: 8'd0});
        d = model_mem[model_ptr];
        model_ptr = model_ptr + 2'd1;
    endtask

    task automatic scl_release();
        int n;
        n = 0;
        scl_m = 1'b1;
        while (scl_line !== 1'b1 && n < WAIT_MAX) begin #10; n++; end
        if (n >= WAIT_MAX) chk("scl_release_timeout", {31'd0, scl_line}, 32'd1);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b; #Q;
        scl_release(); #Q;
        r = sda_line; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], dummy);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic dummy;
        for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
        bit_xfer(mack, dummy);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_release(); #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_release(); #Q;
        sda_m = 1'b1; #Q; #Q;
    endtask

    initial begin
        logic       a;
        logic [7:0] d, e1, e2;

        repeat (4) @(posedge clk);
        for (int i = 0; i < 4; i++) preload(2'(i), 8'h00);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_cyc", {31'd0, cyc_o}, 32'd0);
        chk("rst_we", {31'd0, we_o}, 32'd0);
        chk("rst_adr_dat", {22'd0, adr_o, dat_o}, 32'd0);
        chk("rst_scl_sda", {30'd0, scl_o, sda_o}, 32'd3);

        // Single write: pointer 2, data A5
        i2c_start();
        write_byte(8'h44, a); chk("wr_addr_ack", {31'd0, a}, 32'd0);
        model_ptr = 2'd2;
        write_byte(8'h02, a); chk("wr_ptr_ack", {31'd0, a}, 32'd0);
        model_wr(8'hA5);
        write_byte(8'hA5, a); chk("wr_data_ack", {31'd0, a}, 32'd0);
        i2c_stop();
        chk("mem2_a5", {24'd0, mem[2]}, 32'h0000_00A5);

        // Burst across the pointer wrap
        i2c_start();
        write_byte(8'h44, a); chk("burst_addr_ack", {31'd0, a}, 32'd0);
        model_ptr = 2'd3;
        write_byte(8'h03, a); chk("burst_ptr_ack", {31'd0, a}, 32'd0);
        model_wr(8'h11);
        write_byte(8'h11, a); chk("burst_d0_ack", {31'd0, a}, 32'd0);
        model_wr(8'h22);
        write_byte(8'h22, a); chk("burst_d1_ack", {31'd0, a}, 32'd0);
        i2c_stop();
        chk("mem3_mem0", {16'd0, mem[3], mem[0]}, 32'h0000_1122);

        // Read two bytes after a repeated START
        preload(2'd1, 8'h5A);
        preload(2'd2, 8'hC3);
        i2c_start();
        write_byte(8'h44, a); chk("rd_addr_w_ack", {31'd0, a}, 32'd0);
        model_ptr = 2'd1;
        write_byte(8'h01, a); chk("rd_ptr_ack", {31'd0, a}, 32'd0);
        model_rd(e1);
        model_rd(e2);
        i2c_start();
        write_byte(8'h45, a); chk("rd_addr_r_ack", {31'd0, a}, 32'd0);
        read_byte(1'b0, d);
        chk("rd_byte0_model", {24'd0, d}, {24'd0, e1});
        chk("rd_byte0_lit", {24'd0, d}, 32'h0000_005A);
        read_byte(1'b1, d);
        chk("rd_byte1_model", {24'd0, d}, {24'd0, e2});
        chk("rd_byte1_lit", {24'd0, d}, 32'h0000_00C3);
        i2c_stop();

        // Wrong address is not acknowledged
        i2c_start();
        write_byte(8'h46, a); chk("bad_addr_nack", {31'd0, a}, 32'd1);
        i2c_stop();

        // Write timeout: NACK, 255-cycle strobe, pointer unchanged
        ack_en = 1'b0;
        i2c_start();
        write_byte(8'h44, a); chk("to_addr_ack", {31'd0, a}, 32'd0);
        model_ptr = 2'd1;
        write_byte(8'h01, a); chk("to_ptr_ack", {31'd0, a}, 32'd0);
        exp_q.push_back('{we: 1'b1, adr: model_ptr, dat: 8'h77});
        write_byte(8'h77, a); chk("to_data_nack", {31'd0, a}, 32'd1);
        i2c_stop();
        chk("to_cyc_len", last_run, 32'd255);
        ack_en = 1'b1;
        model_rd(e1);
        i2c_start();
        write_byte(8'h45, a); chk("to_rd_addr_ack", {31'd0, a}, 32'd0);
        read_byte(1'b1, d);
        chk("to_ptr_kept_model", {24'd0, d}, {24'd0, e1});
        chk("to_ptr_kept_lit", {24'd0, d}, 32'h0000_005A);
        i2c_stop();

        // Reset while a write is stretching SCL
        ack_en = 1'b0;
        i2c_start();
        write_byte(8'h44, a); chk("rst_addr_ack", {31'd0, a}, 32'd0);
        model_ptr = 2'd2;
        write_byte(8'h02, a); chk("rst_ptr_ack", {31'd0, a}, 32'd0);
        exp_q.push_back('{we: 1'b1, adr: model_ptr, dat: 8'h99});
        fork
            write_byte(8'h99, a);
            begin : rst_branch
                int n;
                n = 0;
                while (cyc_o !== 1'b1 && n < WAIT_MAX) begin @(posedge clk); n++; end
                if (n >= WAIT_MAX) chk("rst_wait_cyc", {31'd0, cyc_o}, 32'd1);
                repeat (5) @(posedge clk); #1;
                chk("pre_rst_held", {30'd0, scl_o, cyc_o}, 32'd1);
                rst = 1'b1; #1;
                chk("mid_rst_scl_sda", {30'd0, scl_o, sda_o}, 32'd3);
                chk("mid_rst_cyc_stb", {30'd0, cyc_o, stb_o}, 32'd0);
                chk("mid_rst_adr_dat", {22'd0, adr_o, dat_o}, 32'd0);
                repeat (3) @(posedge clk); #1;
                rst = 1'b0;
            end
        join
        i2c_stop();
        ack_en = 1'b1;
        model_ptr = 2'd0;
        model_rd(e1);
        i2c_start();
        write_byte(8'h45, a); chk("post_rst_addr_ack", {31'd0, a}, 32'd0);
        read_byte(1'b1, d);
        chk("post_rst_ptr0_model", {24'd0, d}, {24'd0, e1});
        chk("post_rst_ptr0_lit", {24'd0, d}, 32'h0000_0022);
        i2c_stop();

        repeat (10) @(posedge clk);
        chk("exp_q_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
